// File: rtl/io_port_bank.sv
// io_port_bank: MMIO responder with GPIO, timer/compare flag and FIFO-buffered 8N1 UART TX.
module io_port_bank #(
  parameter int CLK_DIV        = 104,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int GPIO_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_txd,
  output logic              irq_timer
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
  localparam int PW    = FIFO_DEPTH_LOG;
  localparam int CW    = FIFO_DEPTH_LOG + 1;
  localparam int DW    = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
  logic [31:0]       timer_q, timer_d, cmp_q, cmp_d;
  logic              match_q, match_d, ovf_q, ovf_d;
  logic [7:0]        mem_q [DEPTH], mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [5:0]        sel;
  logic [1:0]        w1c;
  logic              wr, full, empty, push, accept, pop, div_end;
  logic [31:0]       uart_stat;
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^io_addr[1:0];
  always_comb begin
    sel        = io_addr[7:2];
    wr         = io_en & io_we;
    full       = count_q[FIFO_DEPTH_LOG];
    empty      = count_q == '0;
    push       = wr && sel == 6'h05;
    accept     = push & ~full;
    pop        = state_q == IDLE && !empty;
    gpio_out_d = (wr && sel == 6'h00) ? io_data_write[GPIO_W-1:0] : gpio_out_q;
    timer_d    = (wr && sel == 6'h02) ? io_data_write : timer_q + 32'd1;
    cmp_d      = (wr && sel == 6'h03) ? io_data_write : cmp_q;
    w1c        = (wr && sel == 6'h04) ? io_data_write[1:0] : 2'b00;
    // A fresh match or overflow beats a simultaneous clear
    match_d    = (timer_q == cmp_q) | (match_q & ~w1c[0]);
    ovf_d      = (push & full) | (ovf_q & ~w1c[1]);
    mem_d      = mem_q;
    if (accept) mem_d[wr_ptr_q] = io_data_write[7:0];
    wr_ptr_d   = wr_ptr_q + PW'(accept);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(accept) - CW'(pop);
  end
  always_comb begin
    div_end   = div_q == DW'(CLK_DIV - 1);
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_end ? '0 : div_q + DW'(1);
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!empty) begin
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: if (div_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (div_end) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d   = (bit_cnt_q == 3'd7) ? STOP : DATA;
      end
      default: if (div_end) state_d = IDLE;
    endcase
  end
  always_comb begin
    uart_stat                   = '0;
    uart_stat[FIFO_DEPTH_LOG:0] = count_q;
    uart_stat[16]               = full;
    uart_stat[17]               = empty;
    uart_stat[18]               = state_q != IDLE;
    io_data_read                = '0;
    if (io_en && !io_we)
      case (sel)
        6'h00:   io_data_read = 32'(gpio_out_q);
        6'h01:   io_data_read = 32'(sync2_q);
        6'h02:   io_data_read = timer_q;
        6'h03:   io_data_read = cmp_q;
        6'h04:   io_data_read = {30'b0, ovf_q, match_q};
        6'h06:   io_data_read = uart_stat;
        default: io_data_read = '0;
      endcase
  end
  assign uart_txd  = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[bit_cnt_q] : 1'b1;
  assign gpio_out  = gpio_out_q;
  assign irq_timer = match_q;
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      timer_q    <= '0;
      cmp_q      <= '1;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
    end
  end
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed checks of io_port_bank registers, timer flag and UART TX.
module tb_io_port_bank;
  logic        clk = 0, reset = 1;
  logic [7:0]  io_addr = '0;
  logic        io_en = 0, io_we = 0;
  logic [31:0] io_data_write = '0;
  logic [31:0] io_data_read;
  logic [7:0]  gpio_in = '0, gpio_out;
  logic        uart_txd, irq_timer;
  int          n_tests = 0, n_fail = 0;
  logic [7:0]  bytes [10] = '{8'hC3, 8'h01, 8'h80, 8'h7E, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hEE};
  logic [7:0]  tx_byte, rx_b;
  logic        exp_bit, ok, saw_low;

  io_port_bank #(.CLK_DIV(4), .FIFO_DEPTH_LOG(3), .GPIO_W(8)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_txd(uart_txd), .irq_timer(irq_timer));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_en = 1; io_we = 1; io_addr = a; io_data_write = d;
    @(posedge clk);
    #1 io_en = 0; io_we = 0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    io_en = 1; io_we = 0; io_addr = a;
    #1 chk(tag, io_data_read, exp);
    io_en = 0;
  endtask

  task automatic rx(output logic [7:0] b, output logic found);
    found = 0;
    b = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (uart_txd === 1'b0) found = 1;
    end
    if (found) begin
      repeat (2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(posedge clk);
        #1 b[k] = uart_txd;
      end
      repeat (4) @(posedge clk);
      #1 chk("rx_stop", {31'b0, uart_txd}, 32'h1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    rd("rst_gpio_out", 8'h00, 32'h0);
    io_en = 1; io_addr = 8'h08;
    #1 chk("rst_timer_small", {31'b0, io_data_read < 32'd16}, 32'h1);
    io_en = 0;
    rd("rst_cmp", 8'h0C, 32'hFFFF_FFFF);
    rd("rst_status", 8'h10, 32'h0);
    rd("rst_uart_stat", 8'h18, 32'h0002_0000);
    chk("rst_txd", {31'b0, uart_txd}, 32'h1);
    chk("rst_irq", {31'b0, irq_timer}, 32'h0);

    wr(8'h00, 32'h0000_00A5);
    chk("gpio_out", {24'b0, gpio_out}, 32'hA5);
    rd("gpio_out_rd", 8'h00, 32'hA5);
    @(negedge clk) gpio_in = 8'h3C;
    @(posedge clk); #1 rd("gpio_in_1cyc", 8'h04, 32'h0);
    @(posedge clk); #1 rd("gpio_in_2cyc", 8'h04, 32'h3C);
    wr(8'h04, 32'hFF);
    rd("gpio_in_ro", 8'h04, 32'h3C);
    rd("unmapped", 8'h1C, 32'h0);
    rd("uart_tx_wo", 8'h14, 32'h0);
    io_en = 0; io_addr = 8'h0C;
    #1 chk("io_en_low", io_data_read, 32'h0);

    repeat (50) @(posedge clk);
    wr(8'h0C, 32'd20);
    wr(8'h08, 32'd10);
    rd("timer_load", 8'h08, 32'd10);
    repeat (10) @(posedge clk);
    #1 chk("irq_before", {31'b0, irq_timer}, 32'h0);
    @(posedge clk);
    #1 chk("irq_match", {31'b0, irq_timer}, 32'h1);
    rd("status_match", 8'h10, 32'h1);
    wr(8'h10, 32'h1);
    chk("irq_w1c", {31'b0, irq_timer}, 32'h0);
    rd("status_w1c", 8'h10, 32'h0);
    wr(8'h08, 32'd15);
    chk("irq_pre2", {31'b0, irq_timer}, 32'h0);
    repeat (5) @(posedge clk);
    wr(8'h10, 32'h1);
    chk("irq_set_wins", {31'b0, irq_timer}, 32'h1);
    @(posedge clk);
    #1 rd("status_sticky", 8'h10, 32'h1);
    wr(8'h10, 32'h1);
    rd("status_clr2", 8'h10, 32'h0);

    tx_byte = 8'h55;
    wr(8'h14, {24'b0, tx_byte});
    chk("txd_push_idle", {31'b0, uart_txd}, 32'h1);
    rd("stat_one", 8'h18, 32'h0000_0001);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      exp_bit = (c / 4 == 0) ? 1'b0 : (c / 4 == 9) ? 1'b1 : tx_byte[c/4-1];
      chk($sformatf("txd_c%0d", c), {31'b0, uart_txd}, {31'b0, exp_bit});
    end
    repeat (3) @(posedge clk);
    #1 rd("stat_idle", 8'h18, 32'h0002_0000);

    fork
      begin
        for (int i = 0; i < 10; i++) wr(8'h14, {24'b0, bytes[i]});
        rd("stat_full", 8'h18, 32'h0005_0008);
        rd("status_ovf", 8'h10, 32'h2);
        wr(8'h10, 32'h2);
        rd("status_ovf_clr", 8'h10, 32'h0);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          rx(rx_b, ok);
          chk($sformatf("rx_found%0d", i), {31'b0, ok}, 32'h1);
          chk($sformatf("rx_byte%0d", i), {24'b0, rx_b}, {24'b0, bytes[i]});
        end
      end
    join
    saw_low = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1) saw_low = 1;
    end
    chk("no_dropped_frame", {31'b0, saw_low}, 32'h0);
    rd("stat_drained", 8'h18, 32'h0002_0000);

    wr(8'h14, 32'h00);
    wr(8'h14, 32'h11);
    wr(8'h14, 32'h22);
    repeat (6) @(posedge clk);
    #1 chk("txd_in_data", {31'b0, uart_txd}, 32'h0);
    rd("stat_busy", 8'h18, 32'h0004_0002);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("txd_after_rst", {31'b0, uart_txd}, 32'h1);
    rd("stat_after_rst", 8'h18, 32'h0002_0000);
    saw_low = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1) saw_low = 1;
    end
    chk("fifo_discarded", {31'b0, saw_low}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
